// File: rtl/game_link_rx_pkg.sv
// Shared types and constants for the inter-board game link.
// The state struct is the on-wire DATA byte layout, reused by the transmit side.
package game_link_rx_pkg;

    localparam logic [7:0] LINK_HDR     = 8'hA5;
    localparam logic [7:0] LINK_CHK_KEY = 8'h5A;

    typedef struct packed {
        logic       p1_ready;
        logic       p2_ready;
        logic       throw_flag;
        logic [4:0] power;
    } link_state_t;

    typedef enum logic [1:0] {
        WAIT_HDR,
        WAIT_DATA,
        WAIT_CHK
    } frame_state_t;

    typedef enum logic [1:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP
    } uart_state_t;

    function automatic logic [7:0] link_chk(input link_state_t s);
        return s ^ LINK_CHK_KEY;
    endfunction

endpackage

// File: rtl/game_link_rx_if.sv
// Serial input and decoded remote-player state of the game link receiver.
// master = receiver (drives decoded state), slave = consumer (drives the line).
interface game_link_rx_if;
    logic       rx;
    logic       rx_player1_ready;
    logic       rx_player2_ready;
    logic       rx_throw_flag;
    logic [4:0] rx_power;
    logic       frame_valid;
    logic       frame_err;
    logic       link_up;

    modport master (
        input  rx,
        output rx_player1_ready, rx_player2_ready, rx_throw_flag, rx_power,
        output frame_valid, frame_err, link_up
    );

    modport slave (
        output rx,
        input  rx_player1_ready, rx_player2_ready, rx_throw_flag, rx_power,
        input  frame_valid, frame_err, link_up
    );
endinterface

// File: rtl/game_link_rx_uart.sv
// 8N1 UART receiver with 2-FF input synchroniser, start-bit glitch rejection.
// byte_valid pulses one cycle after the stop-bit sample; no backpressure (bytes are not held).
module link_uart_rx #(
    parameter int CLK_FREQ = 40_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clk40MHz,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       stop_err
);
    import game_link_rx_pkg::*;

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);

    logic        rx_meta, rx_sync, rx_prev;
    uart_state_t state_r, state_nxt;
    logic [CW-1:0] cnt_r, cnt_nxt;
    logic [2:0]  bit_r, bit_nxt;
    logic [7:0]  shift_r, shift_nxt;
    logic [7:0]  data_r, data_nxt;
    logic        bv_r, bv_nxt;
    logic        se_r, se_nxt;

    always_ff @(posedge clk40MHz or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
            state_r <= U_IDLE;
            cnt_r   <= '0;
            bit_r   <= '0;
            shift_r <= '0;
            data_r  <= '0;
            bv_r    <= 1'b0;
            se_r    <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
            bit_r   <= bit_nxt;
            shift_r <= shift_nxt;
            data_r  <= data_nxt;
            bv_r    <= bv_nxt;
            se_r    <= se_nxt;
        end
    end

    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r + 1'b1;
        bit_nxt   = bit_r;
        shift_nxt = shift_r;
        data_nxt  = data_r;
        bv_nxt    = 1'b0;
        se_nxt    = se_r;
        case (state_r)
            U_IDLE: begin
                cnt_nxt = '0;
                if (rx_prev && !rx_sync) state_nxt = U_START;
            end
            U_START: begin
                // Line back high at mid start bit means a glitch, not a character.
                if (cnt_r == CW'(HALF_BIT - 1)) begin
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                    state_nxt = rx_sync ? U_IDLE : U_DATA;
                end
            end
            U_DATA: begin
                if (cnt_r == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_nxt   = '0;
                    shift_nxt = {rx_sync, shift_r[7:1]};
                    if (bit_r == 3'd7) state_nxt = U_STOP;
                    else               bit_nxt   = bit_r + 1'b1;
                end
            end
            U_STOP: begin
                if (cnt_r == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_nxt   = '0;
                    data_nxt  = shift_r;
                    bv_nxt    = 1'b1;
                    se_nxt    = ~rx_sync;
                    state_nxt = U_IDLE;
                end
            end
            default: state_nxt = U_IDLE;
        endcase
    end

    assign data       = data_r;
    assign byte_valid = bv_r;
    assign stop_err   = se_r;

endmodule

// File: rtl/game_link_rx.sv
// Game link receiver: validates HDR/DATA/CHK frames, holds remote player state, tracks link_up.
// Outputs update one cycle after the CHK byte; no backpressure (frames are consumed as they arrive).
module game_link_rx
    import game_link_rx_pkg::*;
#(
    parameter int CLK_FREQ     = 40_000_000,
    parameter int BAUD         = 115_200,
    parameter int LINK_TIMEOUT = 4_000_000
) (
    input  logic           clk40MHz,
    input  logic           rst_n,
    game_link_rx_if.master link
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int BYTE_GAP     = 4 * CLKS_PER_BIT * 10;
    localparam int GW           = $clog2(BYTE_GAP + 1);
    localparam int LW           = $clog2(LINK_TIMEOUT + 1);

    logic [7:0]   rx_byte;
    logic         byte_valid, stop_err;

    frame_state_t fs_r, fs_nxt;
    link_state_t  data_r, data_nxt;
    link_state_t  out_r, out_nxt;
    logic         fv_r, fv_nxt, fe_r, fe_nxt;
    logic         link_up_r, link_up_nxt;
    logic [GW-1:0] gap_r, gap_nxt;
    logic [LW-1:0] link_cnt_r, link_cnt_nxt;

    link_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_uart (
        .clk40MHz  (clk40MHz),
        .rst_n     (rst_n),
        .rx        (link.rx),
        .data      (rx_byte),
        .byte_valid(byte_valid),
        .stop_err  (stop_err)
    );

    always_ff @(posedge clk40MHz or negedge rst_n) begin
        if (!rst_n) begin
            fs_r       <= WAIT_HDR;
            data_r     <= '0;
            out_r      <= '0;
            fv_r       <= 1'b0;
            fe_r       <= 1'b0;
            link_up_r  <= 1'b0;
            gap_r      <= '0;
            link_cnt_r <= '0;
        end else begin
            fs_r       <= fs_nxt;
            data_r     <= data_nxt;
            out_r      <= out_nxt;
            fv_r       <= fv_nxt;
            fe_r       <= fe_nxt;
            link_up_r  <= link_up_nxt;
            gap_r      <= gap_nxt;
            link_cnt_r <= link_cnt_nxt;
        end
    end

    always_comb begin
        fs_nxt   = fs_r;
        data_nxt = data_r;
        out_nxt  = out_r;
        fv_nxt   = 1'b0;
        fe_nxt   = 1'b0;
        gap_nxt  = '0;
        // A byte arriving in the timeout cycle takes priority over the gap error.
        if (byte_valid) begin
            case (fs_r)
                WAIT_HDR: begin
                    if (!stop_err && rx_byte == LINK_HDR) fs_nxt = WAIT_DATA;
                end
                WAIT_DATA: begin
                    if (stop_err) begin
                        fe_nxt = 1'b1;
                        fs_nxt = WAIT_HDR;
                    end else begin
                        data_nxt = link_state_t'(rx_byte);
                        fs_nxt   = WAIT_CHK;
                    end
                end
                WAIT_CHK: begin
                    fs_nxt = WAIT_HDR;
                    if (!stop_err && rx_byte == link_chk(data_r)) begin
                        out_nxt = data_r;
                        fv_nxt  = 1'b1;
                    end else begin
                        fe_nxt = 1'b1;
                    end
                end
                default: fs_nxt = WAIT_HDR;
            endcase
        end else if (fs_r != WAIT_HDR) begin
            if (gap_r == GW'(BYTE_GAP - 1)) begin
                fe_nxt = 1'b1;
                fs_nxt = WAIT_HDR;
            end else begin
                gap_nxt = gap_r + 1'b1;
            end
        end

        link_cnt_nxt = link_cnt_r;
        link_up_nxt  = link_up_r;
        if (fv_nxt) begin
            link_cnt_nxt = '0;
            link_up_nxt  = 1'b1;
        end else if (link_cnt_r != LW'(LINK_TIMEOUT)) begin
            link_cnt_nxt = link_cnt_r + 1'b1;
            if (link_cnt_r == LW'(LINK_TIMEOUT - 1)) link_up_nxt = 1'b0;
        end
    end

    assign link.rx_player1_ready = out_r.p1_ready;
    assign link.rx_player2_ready = out_r.p2_ready;
    assign link.rx_throw_flag    = out_r.throw_flag;
    assign link.rx_power         = out_r.power;
    assign link.frame_valid      = fv_r;
    assign link.frame_err        = fe_r;
    assign link.link_up          = link_up_r;

endmodule

// File: tb/tb_game_link_rx.sv
// Directed frames on the serial line; a monitor checks every frame_valid/frame_err against a queue.
// Baud and link timeout are scaled down so the whole run stays short.
`timescale 1ns/1ps
module tb_game_link_rx;
    import game_link_rx_pkg::*;

    localparam int CLK_FREQ     = 40_000_000;
    localparam int BAUD         = 625_000;
    localparam int CPB          = CLK_FREQ / BAUD;
    localparam int BYTE_GAP     = 4 * CPB * 10;
    localparam int LINK_TIMEOUT = 20_000;

    typedef struct {
        bit         err;
        logic [7:0] st;
    } exp_t;

    logic clk40MHz = 1'b0;
    logic rst_n    = 1'b0;
    int   total    = 0;
    int   bad      = 0;
    exp_t exp_q[$];

    game_link_rx_if link_if ();

    game_link_rx #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD        (BAUD),
        .LINK_TIMEOUT(LINK_TIMEOUT)
    ) dut (
        .clk40MHz(clk40MHz),
        .rst_n   (rst_n),
        .link    (link_if)
    );

    always #12.5 clk40MHz = ~clk40MHz;

    function automatic logic [7:0] out_state();
        return {link_if.rx_player1_ready, link_if.rx_player2_ready,
                link_if.rx_throw_flag, link_if.rx_power};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input bit err, input logic [7:0] st);
        exp_t e;
        e.err = err;
        e.st  = st;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        link_if.rx = 1'b0;
        repeat (CPB) @(posedge clk40MHz);
        for (int i = 0; i < 8; i++) begin
            link_if.rx = b[i];
            repeat (CPB) @(posedge clk40MHz);
        end
        link_if.rx = stop_bit;
        repeat (CPB) @(posedge clk40MHz);
        link_if.rx = 1'b1;
        repeat (CPB / 2) @(posedge clk40MHz);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [7:0] c);
        send_byte(8'hA5, 1'b1);
        send_byte(d, 1'b1);
        send_byte(c, 1'b1);
    endtask

    // Scoreboard monitor: every output event must match the head of the queue.
    always @(negedge clk40MHz) begin
        if (rst_n && (link_if.frame_valid || link_if.frame_err)) begin
            exp_t e;
            check("valid_err_exclusive", 32'(link_if.frame_valid & link_if.frame_err), 0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: frame_valid=%0b frame_err=%0b, expected none",
                         link_if.frame_valid, link_if.frame_err);
            end else begin
                e = exp_q.pop_front();
                check("event_is_err", 32'(link_if.frame_err), 32'(e.err));
                check("decoded_state", 32'(out_state()), 32'(e.st));
                if (!e.err) check("link_up_on_valid", 32'(link_if.link_up), 1);
            end
        end
    end

    initial begin
        link_if.rx = 1'b1;
        rst_n      = 1'b0;
        repeat (5) @(posedge clk40MHz);
        @(negedge clk40MHz);
        check("reset_state", 32'(out_state()), 0);
        check("reset_frame_valid", 32'(link_if.frame_valid), 0);
        check("reset_frame_err", 32'(link_if.frame_err), 0);
        check("reset_link_up", 32'(link_if.link_up), 0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk40MHz);

        // Basic frames, then a checksum mismatch that must leave outputs alone.
        expect_ev(1'b0, 8'h9F);
        send_frame(8'h9F, 8'hC5);
        expect_ev(1'b0, 8'h2F);
        send_frame(8'h2F, 8'h75);
        expect_ev(1'b1, 8'h2F);
        send_frame(8'h2F, 8'h00);

        // Leading junk is ignored silently.
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        expect_ev(1'b0, 8'hC0);
        send_frame(8'hC0, 8'h9A);

        // DATA equal to the header byte is decoded by position.
        expect_ev(1'b0, 8'hA5);
        send_frame(8'hA5, 8'hFF);

        // Inter-byte gap timeout, then recovery.
        expect_ev(1'b1, 8'hA5);
        send_byte(8'hA5, 1'b1);
        repeat (BYTE_GAP + 500) @(posedge clk40MHz);
        expect_ev(1'b0, 8'h80);
        send_frame(8'h80, 8'hDA);

        // Stop bit low in DATA position.
        expect_ev(1'b1, 8'h80);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h2F, 1'b0);
        repeat (CPB) @(posedge clk40MHz);

        // Short low glitch mid-frame must not produce a byte.
        expect_ev(1'b0, 8'h2F);
        send_byte(8'hA5, 1'b1);
        link_if.rx = 1'b0;
        repeat (CPB / 3) @(posedge clk40MHz);
        link_if.rx = 1'b1;
        repeat (2 * CPB) @(posedge clk40MHz);
        send_byte(8'h2F, 1'b1);
        send_byte(8'h75, 1'b1);
        repeat (CPB) @(posedge clk40MHz);
        check("queue_drained_mid", 32'(exp_q.size()), 0);

        // Link timeout: link_up falls exactly LINK_TIMEOUT cycles after frame_valid.
        expect_ev(1'b0, 8'h9F);
        fork
            send_frame(8'h9F, 8'hC5);
            begin : wait_link
                int n;
                n = 0;
                while (!link_if.frame_valid && n < 20_000) begin
                    @(negedge clk40MHz);
                    n++;
                end
                check("frame_valid_seen", 32'(link_if.frame_valid), 1);
                n = 0;
                while (link_if.link_up && n < 3 * LINK_TIMEOUT) begin
                    @(negedge clk40MHz);
                    n++;
                end
                check("link_timeout_cycles", 32'(n), 32'(LINK_TIMEOUT));
            end
        join
        @(negedge clk40MHz);
        check("link_down", 32'(link_if.link_up), 0);
        check("state_retained", 32'(out_state()), 32'h9F);
        check("queue_drained_t6", 32'(exp_q.size()), 0);

        // Asynchronous reset mid-byte clears outputs immediately.
        link_if.rx = 1'b0;
        repeat (100) @(posedge clk40MHz);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_state", 32'(out_state()), 0);
        check("async_reset_link_up", 32'(link_if.link_up), 0);
        repeat (3) @(posedge clk40MHz);
        link_if.rx = 1'b1;
        repeat (5) @(posedge clk40MHz);
        rst_n = 1'b1;
        repeat (10) @(posedge clk40MHz);

        expect_ev(1'b0, 8'hC0);
        send_frame(8'hC0, 8'h9A);
        repeat (CPB) @(posedge clk40MHz);
        check("queue_drained_end", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
